// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM over a shared memory with wait states, timeout and illegal-opcode error.
// Define MC_CONTROLLER_BNE_EN to decode bne (op 000101) into the branch state.
module mc_controller #(
  parameter int ALUCTL_W = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                memreq,
  output logic                memwrite,
  output logic                iord,
  output logic                irwrite,
  output logic                pcen,
  output logic [1:0]          pcsrc,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                err,
  output logic [3:0]          state_dbg_o
);

  // Memory handshake: memreq is held high for the whole access; the access completes
  // in the cycle where memreq && mem_ready, otherwise the FSM holds and counts a wait cycle.

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       fetch;
    logic       branch;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       rtype;
    logic [2:0] alu;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  function automatic ctl_t decode_ctl(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memreq  = 1'b1;
        c.fetch   = 1'b1;
        c.alusrcb = 2'b01;
        c.alu     = ALU_ADD;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        c.alu     = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.alu     = ALU_ADD;
      end
      S_MEMRD: begin
        c.memreq = 1'b1;
        c.iord   = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memreq   = 1'b1;
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTYPE: begin
        c.alusrca = 1'b1;
        c.rtype   = 1'b1;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.branch  = 1'b1;
        c.pcsrc   = 2'b01;
        c.alu     = ALU_SUB;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcen  = 1'b1;
        c.pcsrc = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  ctl_t       ctl_q;
  logic       mem_state;
  logic       timeout;
  logic       br_take;
  logic [2:0] alu3;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    err_d     = err_q;
    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout   = mem_state && !mem_ready && (cnt_q == WAIT_LAST);
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROLLER_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          default: begin
            err_d   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTYPE:  state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    // A stalled access either counts another wait cycle or gives up on the last allowed one.
    if (mem_state && !mem_ready) begin
      if (timeout) begin
        err_d   = 1'b1;
        state_d = S_FETCH;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ctl_q   <= decode_ctl(S_FETCH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ctl_q   <= decode_ctl(state_d);
    end
  end

`ifdef MC_CONTROLLER_BNE_EN
  assign br_take = (op == OP_BNE) ? ~zero : zero;
`else
  assign br_take = zero;
`endif

  assign alu3 = ctl_q.rtype ? funct_alu(funct) : ctl_q.alu;

  always_comb begin
    alucontrol      = '0;
    alucontrol[2:0] = alu3;
  end

  assign memreq      = ctl_q.memreq;
  assign memwrite    = ctl_q.memwrite;
  assign iord        = ctl_q.iord;
  assign irwrite     = ctl_q.fetch & mem_ready;
  assign pcen        = ctl_q.pcen | (ctl_q.fetch & mem_ready) | (ctl_q.branch & br_take);
  assign pcsrc       = ctl_q.pcsrc;
  assign alusrca     = ctl_q.alusrca;
  assign alusrcb     = ctl_q.alusrcb;
  assign regdst      = ctl_q.regdst;
  assign memtoreg    = ctl_q.memtoreg;
  assign regwrite    = ctl_q.regwrite;
  assign err         = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: randomized instruction streams checked cycle by cycle
// against an instruction-level reference model through an expected-vector queue.
module tb_mc_controller;

  localparam int ALUCTL_W = 3;
  localparam int WAIT_MAX = 15;
  localparam int VW       = 17;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_SLT = 3'b111;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic [5:0]          op, funct;
  logic                zero, mem_ready;
  logic                memreq, memwrite, iord, irwrite, pcen;
  logic [1:0]          pcsrc, alusrcb;
  logic                alusrca, regdst, memtoreg, regwrite;
  logic [ALUCTL_W-1:0] alucontrol;
  logic                err;
  logic [3:0]          state_dbg;

  always #5 clk = ~clk;

  mc_controller #(.ALUCTL_W(ALUCTL_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memreq(memreq), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alucontrol(alucontrol), .err(err),
    .state_dbg_o(state_dbg)
  );

  // ---------------- reference model state ----------------
  logic [VW-1:0] exp_q[$];
  logic          err_m = 1'b0;
  logic [5:0]    op_n = '0;
  logic [5:0]    funct_n = '0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [5:0]    fn_tab[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

  function automatic logic [VW-1:0] vec(input logic mreq, mwr, io, irw, pce,
                                        input logic [1:0] psrc, input logic asa,
                                        input logic [1:0] asb, input logic rdst, m2r, rw,
                                        input logic [2:0] alu, input logic e);
    return {mreq, mwr, io, irw, pce, psrc, asa, asb, rdst, m2r, rw, alu, e};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return A_ADD;
      6'b100010: return A_SUB;
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b101010: return A_SLT;
      default:   return A_ADD;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // kind 0 = instruction fetch, 1 = data read, 2 = data write
  function automatic logic [VW-1:0] mem_vec(input int kind, input logic mr);
    case (kind)
      0:       return vec(1'b1, 1'b0, 1'b0, mr, mr, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, A_ADD, err_m);
      1:       return vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, err_m);
      default: return vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, err_m);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rst_v, input logic mr, input logic z, input logic [VW-1:0] e);
    @(posedge clk);
    #1;
    reset     = rst_v;
    mem_ready = mr;
    zero      = z;
    op        = op_n;
    funct     = funct_n;
    exp_q.push_back(e);
  endtask

  // Non-memory cycle: mem_ready and zero are noise the controller must ignore.
  task automatic cyc_free(input logic [VW-1:0] e);
    cyc(1'b0, rbit(), rbit(), e);
  endtask

  task automatic do_reset(input int n);
    err_m = 1'b0;
    repeat (n) cyc(1'b1, 1'b0, rbit(), mem_vec(0, 1'b0));
  endtask

  task automatic mem_access(input int kind, input int waits, output bit to);
    int n;
    n = (waits < WAIT_MAX) ? waits : WAIT_MAX;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rbit(), mem_vec(kind, 1'b0));
    if (waits >= WAIT_MAX) begin
      err_m = 1'b1;
      to    = 1'b1;
    end else begin
      cyc(1'b0, 1'b1, rbit(), mem_vec(kind, 1'b1));
      to = 1'b0;
    end
  endtask

  // zb: 0/1 forces zero during the branch cycle, 2 randomizes it.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm,
                           input int zb);
    bit   to;
    bit   legal;
    logic z;
    op_n    = o;
    funct_n = f;
    mem_access(0, wf, to);
    if (to) return;
    cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, A_ADD, err_m));
    legal = (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ) || (o == OP_ADDI) ||
            (o == OP_J);
`ifdef MC_CONTROLLER_BNE_EN
    if (o == OP_BNE) legal = 1'b1;
`endif
    if (!legal) begin
      err_m = 1'b1;
      return;
    end
    case (o)
      OP_LW, OP_SW: begin
        cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, A_ADD, err_m));
        if (o == OP_LW) begin
          mem_access(1, wm, to);
          if (!to)
            cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000, err_m));
        end else begin
          mem_access(2, wm, to);
        end
      end
      OP_R: begin
        cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, ref_alu(f), err_m));
        cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'b000, err_m));
      end
      OP_BEQ, OP_BNE: begin
        z = (zb > 1) ? rbit() : 1'(zb);
        cyc(1'b0, rbit(), z, vec(1'b0, 1'b0, 1'b0, 1'b0, (o == OP_BEQ) ? z : ~z, 2'b01, 1'b1, 2'b00,
                                 1'b0, 1'b0, 1'b0, A_SUB, err_m));
      end
      OP_ADDI: begin
        cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, A_ADD, err_m));
        cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, err_m));
      end
      default: begin
        cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, err_m));
      end
    endcase
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [VW-1:0] exp_v, act_v;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, regdst, memtoreg,
               regwrite, alucontrol[2:0], err};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL ctl_vec #%0d t=%0t op=%b funct=%b got=%05h exp=%05h (memreq..alu,err)",
                 vectors, $time, op, funct, act_v, exp_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit         to;
    logic [5:0] o, f;
    int         wf, wm;
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    op        = '0;
    funct     = '0;

    do_reset(2);

    run_instr(OP_LW, 6'b000000, 0, 0, 2);
    run_instr(OP_R, 6'b101010, 0, 0, 2);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 1);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 0);
    run_instr(OP_SW, 6'b000000, 0, 3, 2);
    run_instr(OP_R, 6'b100010, 1, 0, 2);
    run_instr(OP_R, 6'b100100, 0, 0, 2);
    run_instr(OP_R, 6'b100101, 0, 0, 2);
    run_instr(OP_R, 6'b111111, 0, 0, 2);
    run_instr(OP_ADDI, 6'b000000, 2, 0, 2);
    run_instr(OP_J, 6'b000000, 0, 0, 2);
    run_instr(OP_LW, 6'b000000, WAIT_MAX - 1, WAIT_MAX - 1, 2);
    run_instr(OP_BNE, 6'b000000, 0, 0, 0);
    run_instr(OP_BNE, 6'b000000, 0, 0, 1);
    run_instr(OP_J, 6'b000000, WAIT_MAX, 0, 2);
    run_instr(OP_LW, 6'b000000, 0, 0, 2);
    do_reset(1);
    run_instr(6'b111111, 6'b000000, 0, 0, 2);
    do_reset(1);
    run_instr(OP_LW, 6'b000000, 0, WAIT_MAX, 2);
    do_reset(1);
    run_instr(OP_SW, 6'b000000, 0, WAIT_MAX + 5, 2);

    // Reset landing in the middle of a load abandons it.
    op_n = OP_LW;
    funct_n = '0;
    mem_access(0, 0, to);
    cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, A_ADD, err_m));
    cyc_free(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, A_ADD, err_m));
    cyc(1'b0, 1'b0, rbit(), mem_vec(1, 1'b0));
    do_reset(2);
    run_instr(OP_R, 6'b100000, 0, 0, 2);

    for (int n = 0; n < 180; n++) begin
      case ($urandom_range(0, 7))
        0:       o = OP_LW;
        1:       o = OP_SW;
        2:       o = OP_R;
        3:       o = OP_BEQ;
        4:       o = OP_ADDI;
        5:       o = OP_J;
        6:       o = OP_BNE;
        default: o = 6'($urandom_range(0, 63));
      endcase
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 5)];
      wf = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      run_instr(o, f, wf, wm, 2);
      if (n % 30 == 29) do_reset($urandom_range(1, 2));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain got=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
